sh_sweep_gen: RTL and testbench

Launch-side companion to the setup/hold-checking flop. It divides the system clock into a slow capture clock, cap_clk. It drives a data line, d_out, that toggles at a programmable tick offset inside each capture period. The offset is swept over a range, one value per period, and each period is flagged with whether the transition violates the checker's setup/hold window. The block drives capture-flop timing benches and margin sweeps.

---
 rtl/sh_sweep_gen.sv | 112 +++++++++++
 tb/tb_sh_sweep_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sh_sweep_gen.sv
// Launch-side sweep generator: divides clk into cap_clk and toggles d_out at a
// programmable tick offset per capture period, sweeping ofs_min..ofs_max.
module sh_sweep_gen #(
    parameter int DIV      = 10,
    parameter int SETUP_TK = 2,
    parameter int HOLD_TK  = 1,
    parameter int OFS_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OFS_W-1:0] ofs_min,
    input  logic [OFS_W-1:0] ofs_max,
    output logic             cap_clk,
    output logic             d_out,
    output logic             expect_viol,
    output logic [OFS_W-1:0] cur_ofs,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, ALIGN, RUN, DONE} state_t;

    localparam logic [OFS_W-1:0] PH_LAST = OFS_W'(DIV - 1);
    localparam logic [OFS_W-1:0] PH_HALF = OFS_W'(DIV / 2);

    state_t           state;
    logic [OFS_W-1:0] ph;
    logic [OFS_W-1:0] ph_nxt;
    logic [OFS_W-1:0] max_q;
    logic             period_start;
    logic             launch;
    int               k_i;

    always_comb begin
        ph_nxt       = (ph == PH_LAST) ? '0 : ph + 1'b1;
        period_start = (ph_nxt == '0);
        // Offset 0 fires on the very edge that enters RUN, so it is launched from ALIGN.
        launch = ((state == ALIGN) && period_start && (cur_ofs == '0)) ||
                 ((state == RUN) && !period_start && (ph_nxt == cur_ofs));
    end

    always_comb begin
        k_i         = int'(cur_ofs);
        expect_viol = (state == RUN) &&
                      ((k_i < HOLD_TK) || ((DIV - k_i) < SETUP_TK));
    end

    // cap_clk and d_out are updated in the same register stage for exact tick alignment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph      <= PH_LAST;
            cap_clk <= 1'b0;
            d_out   <= 1'b0;
        end else begin
            ph      <= ph_nxt;
            cap_clk <= (ph_nxt < PH_HALF);
            if (launch)
                d_out <= ~d_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur_ofs <= '0;
            max_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        max_q <= ofs_max;
                        if ((ofs_min > ofs_max) || (ofs_max > PH_LAST)) begin
                            err   <= 1'b1;
                            state <= DONE;
                        end else begin
                            err     <= 1'b0;
                            cur_ofs <= ofs_min;
                            busy    <= 1'b1;
                            state   <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    if (period_start)
                        state <= RUN;
                end
                RUN: begin
                    if (period_start) begin
                        if (cur_ofs == max_q) begin
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            cur_ofs <= cur_ofs + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sh_sweep_gen.sv
// Directed bench for sh_sweep_gen with DIV=10, SETUP_TK=2, HOLD_TK=1.
module tb_sh_sweep_gen;

    localparam int DIV   = 10;
    localparam int OFS_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [OFS_W-1:0] ofs_min = '0;
    logic [OFS_W-1:0] ofs_max = '0;
    logic             cap_clk, d_out, expect_viol, busy, done, err;
    logic [OFS_W-1:0] cur_ofs;

    int n_chk  = 0;
    int n_fail = 0;
    int tb_ph  = DIV - 1;

    always #5 clk = ~clk;

    sh_sweep_gen #(.DIV(10), .SETUP_TK(2), .HOLD_TK(1), .OFS_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ofs_min(ofs_min), .ofs_max(ofs_max),
        .cap_clk(cap_clk), .d_out(d_out), .expect_viol(expect_viol), .cur_ofs(cur_ofs),
        .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        tb_ph = (tb_ph + 1) % DIV;
    endtask

    task automatic do_start(input int lo, input int hi);
        start   = 1'b1;
        ofs_min = OFS_W'(lo);
        ofs_max = OFS_W'(hi);
        step();
        start = 1'b0;
    endtask

    // Runs until done, checking each toggle lands at ph == offset with the right flag.
    task automatic run_sweep(input int lo, input int hi, input string tag, input int inj);
        int   ntog  = 0;
        int   ndone = 0;
        int   exp_o = lo;
        int   n     = 0;
        logic pd    = d_out;
        bit   cap_ok = 1'b1;
        while (n < 300 && ndone == 0) begin
            step();
            n++;
            if (n == inj) begin
                start = 1'b1; ofs_min = 4'd7; ofs_max = 4'd8;
            end else begin
                start = 1'b0;
            end
            if (cap_clk !== (tb_ph < DIV / 2)) cap_ok = 1'b0;
            if (d_out !== pd) begin
                chk({tag, "_tog_ph"}, tb_ph, exp_o);
                chk({tag, "_tog_ofs"}, cur_ofs, exp_o);
                chk({tag, "_viol"}, expect_viol, (exp_o == 0 || exp_o == 9));
                exp_o++;
                ntog++;
                pd = d_out;
            end
            if (done) ndone++;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, ndone, 1);
        chk({tag, "_ntog"}, ntog, hi - lo + 1);
        chk({tag, "_cap_clk"}, cap_ok, 1);
        step();
        chk({tag, "_done_low"}, done, 0);
        chk({tag, "_busy_low"}, busy, 0);
        chk({tag, "_viol_idle"}, expect_viol, 0);
        chk({tag, "_ofs_end"}, cur_ofs, hi);
    endtask

    initial begin
        int   n;
        int   tog_n;
        int   rise_n;
        logic pd;
        logic pc;
        bit   ok_d;
        bit   ok_b;

        // Reset values
        #2;
        chk("rst_cap_clk", cap_clk, 0);
        chk("rst_d_out", d_out, 0);
        chk("rst_viol", expect_viol, 0);
        chk("rst_cur_ofs", cur_ofs, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("first_rise", cap_clk, 1);

        // Full sweep 0..9
        repeat (3) step();
        do_start(0, 9);
        chk("full_busy", busy, 1);
        chk("full_err", err, 0);
        run_sweep(0, 9, "full", -1);

        // Alignment: start while ph == 3, min=2
        n = 0;
        while (tb_ph != 3 && n < 20) begin step(); n++; end
        do_start(2, 3);
        chk("align_busy", busy, 1);
        n = 1; tog_n = 0; rise_n = 0;
        pd = d_out; pc = cap_clk;
        while (n < 30 && tog_n == 0) begin
            step();
            n++;
            if (cap_clk && !pc && rise_n == 0) rise_n = n;
            pc = cap_clk;
            if (d_out !== pd) tog_n = n;
        end
        chk("align_rise_step", rise_n, 7);
        chk("align_tog_step", tog_n, 9);
        chk("align_tog_ph", tb_ph, 2);
        run_sweep(3, 3, "align", -1);

        // Illegal range: min > max
        pd = d_out;
        do_start(5, 2);
        chk("ill_err", err, 1);
        chk("ill_busy", busy, 0);
        chk("ill_done_early", done, 0);
        step();
        chk("ill_done", done, 1);
        step();
        chk("ill_done_low", done, 0);
        chk("ill_d_out", d_out, pd);

        // Illegal range: max >= DIV
        do_start(0, 10);
        chk("oor_err", err, 1);
        chk("oor_busy", busy, 0);
        step();
        chk("oor_done", done, 1);
        step();
        chk("oor_done_low", done, 0);
        chk("oor_d_out", d_out, pd);

        // Legal start clears err
        do_start(4, 4);
        chk("clr_err", err, 0);
        chk("clr_busy", busy, 1);
        run_sweep(4, 4, "single", -1);

        // Busy protection: a second start lands mid-RUN
        do_start(1, 3);
        run_sweep(1, 3, "prot", 15);
        chk("prot_err", err, 0);

        // Reset mid-RUN at cur_ofs == 4
        do_start(0, 9);
        n = 0;
        while (cur_ofs != 4 && n < 200) begin step(); n++; end
        chk("mid_reach4", cur_ofs, 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_cap_clk", cap_clk, 0);
        chk("mid_d_out", d_out, 0);
        chk("mid_viol", expect_viol, 0);
        chk("mid_cur_ofs", cur_ofs, 0);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tb_ph = DIV - 1;
        step();
        chk("post_first_rise", cap_clk, 1);
        ok_d = 1'b1; ok_b = 1'b1;
        for (int i = 0; i < 25; i++) begin
            step();
            if (d_out !== 1'b0) ok_d = 1'b0;
            if (busy !== 1'b0) ok_b = 1'b0;
        end
        chk("post_no_toggle", ok_d, 1);
        chk("post_idle", ok_b, 1);
        chk("post_cur_ofs", cur_ofs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
